// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and the UART wrapper.
//   BR_W / DATA_W : baud-select and data byte widths
//   BR_*          : baud-select encodings understood by the UART wrapper
//   state_t       : scheduler FSM states
//   slot_t        : payload presented by one requester
package uart_pkg;

  localparam int unsigned BR_W   = 3;
  localparam int unsigned DATA_W = 8;

  // Baud-select encodings shared with the UART wrapper BR_Select input.
  localparam logic [BR_W-1:0] BR_9600   = 3'd0;
  localparam logic [BR_W-1:0] BR_19200  = 3'd1;
  localparam logic [BR_W-1:0] BR_38400  = 3'd2;
  localparam logic [BR_W-1:0] BR_57600  = 3'd3;
  localparam logic [BR_W-1:0] BR_115200 = 3'd4;
  localparam logic [BR_W-1:0] BR_230400 = 3'd5;
  localparam logic [BR_W-1:0] BR_460800 = 3'd6;
  localparam logic [BR_W-1:0] BR_921600 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BR_W-1:0]   br;
  } slot_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request levels
//   ptr     : slot with highest priority this round
//   grant_c : one-hot grant of first set req at or above ptr (with wrap)
//   idx_c   : binary index of grant_c
//   valid_c : any request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] idx_c,
  output logic                       valid_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] slot;
  logic             found;

  // Walk slots starting at ptr, take the first requester found.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    slot    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[slot]) begin
        found         = 1'b1;
        grant_c[slot] = 1'b1;
        idx_c         = slot;
      end
    end
    valid_c = found;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one variable-baud UART transmitter.
//   clk, rst_n          : clock, async active-low reset
//   req/req_data/req_br : per-slot request level, byte and baud select
//   grant               : one-hot, held for the whole service interval
//   ack                 : one-cycle pulse per slot when its frame completes
//   err                 : one-cycle pulse when tx_busy never rose
//   tx_enable           : one-cycle start pulse to the UART
//   tx_data/br_select   : byte and baud select to the UART
//   tx_busy             : UART frame in progress
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [BR_W*NUM_REQ-1:0]   req_br,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      tx_enable,
  output logic [DATA_W-1:0]         tx_data,
  output logic [BR_W-1:0]           br_select,
  input  logic                      tx_busy
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > START_TIMEOUT) ? SETTLE_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_REQ - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               settling_q, settling_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [BR_W-1:0]    br_lat_q, br_lat_d;
  logic [NUM_REQ-1:0] grant_d, ack_d;
  logic               err_d, tx_enable_d;
  logic [DATA_W-1:0]  tx_data_d;
  logic [BR_W-1:0]    br_select_d;

  logic [NUM_REQ-1:0] arb_grant_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_valid_c;
  slot_t              sel_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Payload of the slot the arbiter would pick.
  always_comb begin
    sel_c.data = req_data[32'(arb_idx_c)*DATA_W +: DATA_W];
    sel_c.br   = req_br[32'(arb_idx_c)*BR_W +: BR_W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (arb_valid_c) state_d = ST_CONFIG;
      // First CONFIG cycle decides whether a settle period is needed.
      ST_CONFIG: begin
        if (settling_q) begin
          if (cnt_q == SETTLE_LAST) state_d = ST_START;
        end else if (br_lat_q == br_select) begin
          state_d = ST_START;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)                     state_d = ST_WAIT_DONE;
        else if (cnt_q == TIMEOUT_LAST) state_d = ST_FAIL;
      end
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_DONE;
      ST_DONE,
      ST_FAIL:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of counters and output registers; outputs are registered
  // so that they are valid during the state that the transition enters.
  always_comb begin
    cnt_d       = cnt_q;
    settling_d  = settling_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    br_lat_d    = br_lat_q;
    grant_d     = grant;
    ack_d       = '0;
    err_d       = 1'b0;
    tx_enable_d = (state_d == ST_START);
    tx_data_d   = tx_data;
    br_select_d = br_select;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          grant_d    = arb_grant_c;
          gnt_idx_d  = arb_idx_c;
          tx_data_d  = sel_c.data;
          br_lat_d   = sel_c.br;
          settling_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_CONFIG: begin
        if (settling_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (br_lat_q != br_select) begin
          br_select_d = br_lat_q;
          settling_d  = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_START: begin
        cnt_d      = '0;
        settling_d = 1'b0;
      end
      ST_WAIT_BUSY: begin
        if (!tx_busy) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TIMEOUT_LAST) begin
            err_d   = 1'b1;
            grant_d = '0;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          ack_d   = grant;
          grant_d = '0;
        end
      end
      ST_DONE,
      ST_FAIL: begin
        rr_ptr_d = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      settling_q <= 1'b0;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      br_lat_q   <= '0;
      grant      <= '0;
      ack        <= '0;
      err        <= 1'b0;
      tx_enable  <= 1'b0;
      tx_data    <= '0;
      br_select  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      settling_q <= settling_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      br_lat_q   <= br_lat_d;
      grant      <= grant_d;
      ack        <= ack_d;
      err        <= err_d;
      tx_enable  <= tx_enable_d;
      tx_data    <= tx_data_d;
      br_select  <= br_select_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected
// start/ack/err events, a monitor pops and compares them as they appear.
module tb_uart_tx_scheduler;

  localparam int unsigned N = 4;
  localparam int K_START = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] vec;
    logic [7:0]   data;
    logic [2:0]   br;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [3*N-1:0] req_br = '0;
  logic [N-1:0] grant, ack;
  logic         err, tx_enable;
  logic [7:0]   tx_data;
  logic [2:0]   br_select;
  logic         tx_busy;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_len = 20;
  logic busy_ok = 1'b1;
  logic [N-1:0] hold = '0;
  logic [N-1:0] last_gnt = '0;

  uart_tx_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(2), .START_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .req_br    (req_br),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .br_select (br_select),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input logic [N-1:0] vec,
                               input logic [7:0] data, input logic [2:0] br, input int c);
    exp_t e;
    e.kind = kind; e.vec = vec; e.data = data; e.br = br; e.cyc = c;
    sb.push_back(e);
  endfunction

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [7:0] d, input logic [2:0] b);
    req_data[i*8 +: 8] = d;
    req_br[i*3 +: 3]   = b;
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    sync();
    sync();
    rst_n = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (tx_busy !== lvl && n < budget) begin
      sync();
      n++;
    end
    check(name, 32'(tx_busy), 32'(lvl));
  endtask

  // Runs until every expected event has been seen; models requesters
  // dropping req on their ack (or err) unless told to hold it.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      sync();
      n++;
      if (|grant) last_gnt = grant;
      req = req & ~(ack & ~hold);
      if (err) begin
        req = req & ~(last_gnt & ~hold);
        busy_ok = 1'b1;
      end
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    req = '0;
    repeat (3) sync();
  endtask

  // UART model: busy rises one cycle after the start pulse.
  initial begin : uart_model
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_enable && busy_ok) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops one expectation per observed event, plus invariants.
  initial begin : monitor
    exp_t       e;
    logic [2:0] prev_br;
    logic       prev_rst;
    prev_br  = '0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!$onehot0(grant)) check("grant_onehot", 32'(grant), 32'(0));
        if (prev_rst && br_select != prev_br && (tx_busy || tx_enable || grant == '0))
          check("br_change_window", 32'(br_select), 32'(prev_br));
        if (tx_enable || (|ack) || err) begin
          if (sb.size() == 0) begin
            check("unexpected_event", {29'd0, err, |ack, tx_enable}, 32'd0);
          end else begin
            e = sb.pop_front();
            if (tx_enable) begin
              check("start_kind", 32'(K_START), 32'(e.kind));
              check("start_grant", 32'(grant), 32'(e.vec));
              check("start_data", 32'(tx_data), 32'(e.data));
              check("start_br", 32'(br_select), 32'(e.br));
              if (e.cyc >= 0) check("start_cycle", 32'(cyc), 32'(e.cyc));
            end else if (|ack) begin
              check("ack_kind", 32'(K_ACK), 32'(e.kind));
              check("ack_vec", 32'(ack), 32'(e.vec));
              check("ack_grant_low", 32'(grant), 32'd0);
              if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end else begin
              check("err_kind", 32'(K_ERR), 32'(e.kind));
              check("err_grant_low", 32'(grant), 32'd0);
              if (e.cyc >= 0) check("err_cycle", 32'(cyc), 32'(e.cyc));
            end
          end
        end
      end
      prev_br  = br_select;
      prev_rst = rst_n;
    end
  end

  initial begin : stim
    int k;
    repeat (3) sync();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_br_select", 32'(br_select), 32'd0);
    rst_n = 1'b1;
    sync();
    check("idle_grant", 32'(grant), 32'd0);

    // Single request, baud already matches.
    busy_len = 20;
    set_slot(0, 8'hA5, 3'b000);
    req = 4'b0001; k = cyc + 1;
    push(K_START, 4'b0001, 8'hA5, 3'b000, k + 1);
    push(K_ACK,   4'b0001, 8'h00, 3'b000, k + 23);
    drain(80);
    check("t1_br_hold", 32'(br_select), 32'd0);

    // Baud change on slot 2 adds the settle delay.
    set_slot(2, 8'h3C, 3'b011);
    req = 4'b0100; k = cyc + 1;
    push(K_START, 4'b0100, 8'h3C, 3'b011, k + 3);
    push(K_ACK,   4'b0100, 8'h00, 3'b000, k + 25);
    @(negedge clk);
    check("t2_br_before", 32'(br_select), 32'd0);
    @(negedge clk);
    check("t2_br_loaded", 32'(br_select), 32'd3);
    drain(80);

    // Round robin with three held requests, pointer freshly reset.
    do_reset();
    busy_len = 3;
    set_slot(0, 8'h11, 3'b000);
    set_slot(1, 8'h22, 3'b000);
    set_slot(3, 8'h44, 3'b000);
    hold = 4'b1011;
    req = 4'b1011; k = cyc + 1;
    push(K_START, 4'b0001, 8'h11, 3'b000, k + 1);
    push(K_ACK,   4'b0001, 8'h00, 3'b000, k + 6);
    push(K_START, 4'b0010, 8'h22, 3'b000, -1);
    push(K_ACK,   4'b0010, 8'h00, 3'b000, -1);
    push(K_START, 4'b1000, 8'h44, 3'b000, -1);
    push(K_ACK,   4'b1000, 8'h00, 3'b000, -1);
    push(K_START, 4'b0001, 8'h11, 3'b000, -1);
    push(K_ACK,   4'b0001, 8'h00, 3'b000, -1);
    drain(200);
    hold = '0;

    // Start timeout on slot 2, then pending slot 0 is served.
    busy_ok = 1'b0;
    set_slot(0, 8'h66, 3'b000);
    set_slot(2, 8'h77, 3'b000);
    req = 4'b0101; k = cyc + 1;
    push(K_START, 4'b0100, 8'h77, 3'b000, k + 1);
    push(K_ERR,   4'b0000, 8'h00, 3'b000, k + 18);
    push(K_START, 4'b0001, 8'h66, 3'b000, k + 21);
    push(K_ACK,   4'b0001, 8'h00, 3'b000, k + 26);
    drain(120);

    // Reset during WAIT_DONE; search restarts from slot 0.
    busy_len = 20;
    set_slot(0, 8'h5A, 3'b101);
    set_slot(1, 8'hC3, 3'b101);
    req = 4'b0011; k = cyc + 1;
    push(K_START, 4'b0010, 8'hC3, 3'b101, k + 3);
    wait_busy(1'b1, 40, "t5_busy_rise");
    repeat (3) sync();
    check("t5_pre_reset_queue", 32'(sb.size()), 32'd0);
    check("t5_pre_reset_grant", 32'(grant), 32'h2);
    rst_n = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_ack", 32'(ack), 32'd0);
    check("t5_async_err", 32'(err), 32'd0);
    check("t5_async_tx_enable", 32'(tx_enable), 32'd0);
    check("t5_async_tx_data", 32'(tx_data), 32'd0);
    check("t5_async_br_select", 32'(br_select), 32'd0);
    push(K_START, 4'b0001, 8'h5A, 3'b101, -1);
    push(K_ACK,   4'b0001, 8'h00, 3'b000, -1);
    push(K_START, 4'b0010, 8'hC3, 3'b101, -1);
    push(K_ACK,   4'b0010, 8'h00, 3'b000, -1);
    wait_busy(1'b0, 40, "t5_frame_end");
    sync();
    rst_n = 1'b1;
    drain(150);

    // Slot 1 drops req mid-frame; ack still expected.
    busy_len = 6;
    set_slot(1, 8'h99, 3'b101);
    req = 4'b0010; k = cyc + 1;
    push(K_START, 4'b0010, 8'h99, 3'b101, k + 1);
    push(K_ACK,   4'b0010, 8'h00, 3'b000, k + 9);
    wait_busy(1'b1, 20, "t6_busy_rise");
    sync();
    req = '0;
    drain(60);
    check("t6_br_stable", 32'(br_select), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
